fwd_hazard_ctrl: RTL and testbench

- Control end of the EX-stage ALU operand forwarding path in the 5-stage 16-bit RISC pipeline (IF/ID/EX/MEM/WB).
- Tracks destination-register info for the instructions in EX, MEM and WB.
- Produces registered 2-bit select codes for both ALU operand muxes (0 = register file, 1 = MEM forward, 2 = WB forward).
- Detects load-use hazards, requests a one-cycle stall and inserts the EX bubble.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/fwd_match.sv | 21 ++
 rtl/fwd_hazard_ctrl.sv | 96 +++++++++
 tb/tb_fwd_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the EX-stage operand forwarding control.
package pipe_pkg;

  localparam int unsigned REG_AW = 4;

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic              reg_wr;
    logic              mem_rd;
    logic [REG_AW-1:0] dst;
  } stage_t;

  localparam stage_t STAGE_IDLE = '0;

  // Newest producer wins: the one now in EX will sit in MEM next cycle.
  function automatic logic [1:0] sel_pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return SEL_MEM;
    end else if (mem_hit) begin
      return SEL_WB;
    end
    return SEL_REG;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Combinational test: does this pipeline stage write the given source register?
module fwd_match
  import pipe_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  stage_t            stage,
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  output logic              match_c
);

  logic src_is_zero;
  logic unused_mem_rd;

  assign src_is_zero   = ZERO_REG && (src == REG_AW'(0));
  assign unused_mem_rd = stage.mem_rd;

  assign match_c = stage.valid & stage.reg_wr & (stage.dst == src) & src_used & ~src_is_zero;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall control for the EX-stage ALU operand muxes.
module fwd_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_wr,
  input  logic              id_mem_rd,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        sel1,
  output logic [1:0]        sel2,
  output logic [CNT_W-1:0]  stall_count
);

  stage_t ex_q, ex_d;
  stage_t mem_q;
  stage_t wb_q;
  logic [1:0]       sel1_q, sel1_d;
  logic [1:0]       sel2_q, sel2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex1_hit, ex2_hit, mem1_hit, mem2_hit;
  logic advance;
  logic unused_wb;

  fwd_match #(.ZERO_REG(ZERO_REG)) u_ex_src1 (
    .stage(ex_q), .src(id_src1), .src_used(id_use1), .match_c(ex1_hit)
  );
  fwd_match #(.ZERO_REG(ZERO_REG)) u_ex_src2 (
    .stage(ex_q), .src(id_src2), .src_used(id_use2), .match_c(ex2_hit)
  );
  fwd_match #(.ZERO_REG(ZERO_REG)) u_mem_src1 (
    .stage(mem_q), .src(id_src1), .src_used(id_use1), .match_c(mem1_hit)
  );
  fwd_match #(.ZERO_REG(ZERO_REG)) u_mem_src2 (
    .stage(mem_q), .src(id_src2), .src_used(id_use2), .match_c(mem2_hit)
  );

  // A WB writer has reached the register file before its consumer reads operands in EX.
  assign unused_wb = ^wb_q;

  // Load in EX feeding the ID instruction: its data only exists after MEM.
  assign stall   = id_valid & ~flush & ex_q.valid & ex_q.mem_rd & (ex1_hit | ex2_hit);
  assign advance = id_valid & ~stall & ~flush;

  always_comb begin
    ex_d   = STAGE_IDLE;
    sel1_d = SEL_REG;
    sel2_d = SEL_REG;
    cnt_d  = cnt_q;
    if (advance) begin
      ex_d.valid  = 1'b1;
      ex_d.reg_wr = id_reg_wr;
      ex_d.mem_rd = id_mem_rd;
      ex_d.dst    = id_dst;
      sel1_d      = sel_pick(ex1_hit, mem1_hit);
      sel2_d      = sel_pick(ex2_hit, mem2_hit);
    end
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= STAGE_IDLE;
      mem_q  <= STAGE_IDLE;
      wb_q   <= STAGE_IDLE;
      sel1_q <= SEL_REG;
      sel2_q <= SEL_REG;
      cnt_q  <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= ex_q;
      wb_q   <= mem_q;
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sel1        = sel1_q;
  assign sel2        = sel2_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding selects, load-use stall, flush and reset.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_src1, id_src2, id_dst;
  logic        id_use1, id_use2, id_reg_wr, id_mem_rd;
  logic        flush;
  logic        stall;
  logic [1:0]  sel1, sel2;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  fwd_hazard_ctrl #(.ZERO_REG(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .id_dst(id_dst), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .flush(flush),
    .stall(stall), .sel1(sel1), .sel2(sel2), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2, input logic [3:0] d,
                        input logic wr, input logic rd, input logic fl);
    id_valid  = v;
    id_src1   = s1;
    id_use1   = u1;
    id_src2   = s2;
    id_use2   = u2;
    id_dst    = d;
    id_reg_wr = wr;
    id_mem_rd = rd;
    flush     = fl;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) step();
    rst = 1'b0;
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL reset_sel1 got=%0d exp=0", sel1); end
    checks++; if (sel2 !== 2'd0) begin errors++; $display("FAIL reset_sel2 got=%0d exp=0", sel2); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", stall_count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);  // ADD r3
    step();
    set_id(1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0); // SUB reads r3
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got=%0b exp=0", stall); end
    step();
    checks++; if (sel1 !== 2'd1) begin errors++; $display("FAIL b2b_sel1 got=%0d exp=1", sel1); end
    checks++; if (sel2 !== 2'd0) begin errors++; $display("FAIL b2b_sel2 got=%0d exp=0", sel2); end
    drain();
  endtask

  task automatic test_wb_forward();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);  // writes r5
    step();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);  // independent
    step();
    set_id(1'b1, 4'd6, 1'b1, 4'd5, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0); // reads r5 on src2
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb_stall got=%0b exp=0", stall); end
    step();
    checks++; if (sel2 !== 2'd2) begin errors++; $display("FAIL wb_sel2 got=%0d exp=2", sel2); end
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL wb_sel1 got=%0d exp=0", sel1); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0);  // LD r4
    step();
    set_id(1'b1, 4'd4, 1'b1, 4'd2, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0); // uses r4
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b exp=1", stall); end
    step();
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL lu_bubble_sel1 got=%0d exp=0", sel1); end
    checks++; if (sel2 !== 2'd0) begin errors++; $display("FAIL lu_bubble_sel2 got=%0d exp=0", sel2); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once got=%0b exp=0", stall); end
    step();
    checks++; if (sel1 !== 2'd2) begin errors++; $display("FAIL lu_sel1 got=%0d exp=2", sel1); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count_hold got=%0d exp=1", stall_count); end
    drain();
  endtask

  task automatic test_priority_zero();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 4'd2, 1'b1, 4'd1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 4'd13, 1'b1, 1'b0, 1'b0); // src1 == src2 == r7
    step();
    checks++; if (sel1 !== 2'd1) begin errors++; $display("FAIL prio_sel1 got=%0d exp=1", sel1); end
    checks++; if (sel2 !== 2'd1) begin errors++; $display("FAIL prio_sel2 got=%0d exp=1", sel2); end
    drain();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);  // writes r0
    step();
    set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd14, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL zero_sel1 got=%0d exp=0", sel1); end
    checks++; if (sel2 !== 2'd0) begin errors++; $display("FAIL zero_sel2 got=%0d exp=0", sel2); end
    drain();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);  // LD r0
    step();
    set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd14, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got=%0b exp=0", stall); end
    drain();
  endtask

  task automatic test_flush();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0);  // LD r4
    step();
    set_id(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1);  // flushed LD r8 using r4
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%0b exp=0", stall); end
    step();
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL flush_sel1 got=%0d exp=0", sel1); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL flush_count got=%0d exp=1", stall_count); end
    set_id(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);  // would hit r8 if it entered EX
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_bubble_stall got=%0b exp=0", stall); end
    step();
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL flush_bubble_sel1 got=%0d exp=0", sel1); end
    drain();
  endtask

  task automatic test_mid_reset();
    for (int i = 1; i <= 3; i++) begin
      set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'(i), 1'b1, 1'b0, 1'b0);
      step();
    end
    set_id(1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL mrst_sel1 got=%0d exp=0", sel1); end
    checks++; if (sel2 !== 2'd0) begin errors++; $display("FAIL mrst_sel2 got=%0d exp=0", sel2); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL mrst_count got=%0d exp=0", stall_count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mrst_stall got=%0b exp=0", stall); end
    step();
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL mrst_cons_sel1 got=%0d exp=0", sel1); end
    checks++; if (sel2 !== 2'd0) begin errors++; $display("FAIL mrst_cons_sel2 got=%0d exp=0", sel2); end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_back_to_back();
    test_wb_forward();
    test_load_use();
    test_priority_zero();
    test_flush();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
